adpcm_enc_ctrl: RTL and testbench

ADPCM_ENC_CTRL -- requirements
Module: adpcm_enc_ctrl

---
 rtl/adpcm_enc_ctrl_if.sv | 32 +++
 rtl/adpcm_enc_ctrl.sv | 160 ++++++++++++++++
 tb/tb_adpcm_enc_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adpcm_enc_ctrl_if.sv
// adpcm_enc_ctrl_if: groups the sample input, encoder strobe/code and packed
// output streams of the ADPCM encoder controller.
//   s_valid/s_ready/s_sample    : PCM sample input handshake
//   enc_sample/enc_en/enc_code  : encoder feed, advance strobe, returned code
//   enc_clr                     : encoder predictor clear pulse
//   m_valid/m_ready/m_data/m_last : packed-code output handshake
//   flush                       : level request to end the current block early
// Modport master is the controller; slave is the surrounding system.
interface adpcm_enc_ctrl_if;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_sample;
  logic [15:0] enc_sample;
  logic        enc_en;
  logic [3:0]  enc_code;
  logic        enc_clr;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;
  logic        flush;

  modport master (
    input  s_valid, s_sample, enc_code, m_ready, flush,
    output s_ready, enc_sample, enc_en, enc_clr, m_valid, m_data, m_last
  );

  modport slave (
    output s_valid, s_sample, enc_code, m_ready, flush,
    input  s_ready, enc_sample, enc_en, enc_clr, m_valid, m_data, m_last
  );
endinterface

// File: rtl/adpcm_enc_ctrl.sv
// adpcm_enc_ctrl: feeds PCM samples to an ADPCM encoder, packs the returned
// 4-bit codes four per 16-bit word and frames them into blocks of BLOCK_LEN
// samples, with early termination on flush.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : adpcm_enc_ctrl_if.master (sample in, encoder feed, word out)
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | after reset, moves to S_CLR on the next cycle
// S_CLR   | one-cycle encoder clear; counter, nibble index, pack zeroed
// S_RUN   | accepting samples, packing codes
// S_DRAIN | block ending: finish in-flight capture, emit final word
// S_LAST  | final (m_last) word held until it handshakes
module adpcm_enc_ctrl #(
  parameter int BLOCK_LEN = 256
) (
  input  logic             clk,
  input  logic             reset_n,
  adpcm_enc_ctrl_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_DRAIN, S_LAST} state_t;

  localparam logic [15:0] LP_LAST_CNT = 16'(BLOCK_LEN - 1);

  state_t      r_state, w_state_nx;
  logic [15:0] r_cnt, w_cnt_nx;
  logic [1:0]  r_k, w_k_nx;
  logic [15:0] r_pack, w_pack_nx, w_pack_cap;
  logic        r_cap_pend;
  logic        r_m_valid, w_m_valid_nx;
  logic        r_m_last, w_m_last_nx;
  logic [15:0] r_m_data, w_m_data_nx;
  logic        w_s_ready, w_enc_en, w_enc_clr, w_retire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_k        <= '0;
      r_pack     <= '0;
      r_cap_pend <= 1'b0;
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_m_data   <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_k        <= w_k_nx;
      r_pack     <= w_pack_nx;
      r_cap_pend <= w_enc_en;
      r_m_valid  <= w_m_valid_nx;
      r_m_last   <= w_m_last_nx;
      r_m_data   <= w_m_data_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_k_nx       = r_k;
    w_pack_nx    = r_pack;
    w_m_valid_nx = r_m_valid;
    w_m_last_nx  = r_m_last;
    w_m_data_nx  = r_m_data;
    w_enc_clr    = 1'b0;

    // Holding off samples while a word is pending guarantees the output
    // register is never overwritten before it retires.
    w_s_ready  = (r_state == S_RUN) && !r_m_valid && !bus.flush;
    w_enc_en   = bus.s_valid && w_s_ready;
    w_retire   = r_m_valid && bus.m_ready;
    w_pack_cap = r_pack | (16'(bus.enc_code) << {r_k, 2'b00});

    if (w_retire) begin
      w_m_valid_nx = 1'b0;
      w_m_last_nx  = 1'b0;
    end

    if (w_enc_en) begin
      w_cnt_nx = r_cnt + 16'd1;
    end

    // Code for the sample accepted last cycle lands now.
    if (r_cap_pend) begin
      w_k_nx = r_k + 2'd1;
      if (r_k == 2'd3) begin
        w_m_data_nx  = w_pack_cap;
        w_m_valid_nx = 1'b1;
        w_m_last_nx  = (r_state == S_DRAIN);
        w_pack_nx    = '0;
      end else begin
        w_pack_nx = w_pack_cap;
      end
    end

    case (r_state)
      S_IDLE: w_state_nx = S_CLR;
      S_CLR: begin
        w_enc_clr  = 1'b1;
        w_cnt_nx   = '0;
        w_k_nx     = '0;
        w_pack_nx  = '0;
        w_state_nx = S_RUN;
      end
      S_RUN: begin
        // Length limit wins; flush cannot coincide with an accept anyway
        // because flush masks s_ready.
        if (w_enc_en && (r_cnt == LP_LAST_CNT)) begin
          w_state_nx = S_DRAIN;
        end else if (bus.flush && (r_cnt != 16'd0)) begin
          w_state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_cap_pend) begin
          if (r_k == 2'd3) begin
            w_state_nx = S_LAST;
          end
        end else if (r_k != 2'd0) begin
          // Partial word waits for the output slot to free up.
          if (!r_m_valid || bus.m_ready) begin
            w_m_data_nx  = r_pack;
            w_m_valid_nx = 1'b1;
            w_m_last_nx  = 1'b1;
            w_pack_nx    = '0;
            w_k_nx       = '0;
            w_state_nx   = S_LAST;
          end
        end else if (r_m_valid && !bus.m_ready) begin
          w_m_last_nx = 1'b1;
          w_state_nx  = S_LAST;
        end else begin
          // Nothing left to mark: close the block with an empty word.
          w_m_data_nx  = '0;
          w_m_valid_nx = 1'b1;
          w_m_last_nx  = 1'b1;
          w_state_nx   = S_LAST;
        end
      end
      S_LAST: begin
        if (w_retire) begin
          w_state_nx = S_CLR;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign bus.s_ready    = w_s_ready;
  assign bus.enc_en     = w_enc_en;
  assign bus.enc_clr    = w_enc_clr;
  assign bus.enc_sample = bus.s_sample;
  assign bus.m_valid    = r_m_valid;
  assign bus.m_last     = r_m_last;
  assign bus.m_data     = r_m_data;

endmodule

// File: tb/tb_adpcm_enc_ctrl.sv
module tb_adpcm_enc_ctrl;
  localparam int BL = 8;

  logic clk = 1'b0;
  logic reset_n;

  adpcm_enc_ctrl_if bus();

  adpcm_enc_ctrl #(.BLOCK_LEN(BL)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  int          clr_cnt = 0;
  logic [3:0]  scr_q[$];
  logic [3:0]  iss_q[$];
  logic [16:0] obs_q[$];

  // Encoder stand-in: returns a code the cycle after each enc_en.
  initial begin : resp
    logic       hit;
    logic [3:0] code;
    bus.enc_code = '0;
    forever begin
      @(negedge clk); #2;
      hit = (bus.enc_en === 1'b1);
      @(posedge clk); #1;
      if (hit) begin
        code = (scr_q.size() > 0) ? scr_q.pop_front() : 4'($urandom_range(0, 15));
        bus.enc_code = code;
        iss_q.push_back(code);
      end
    end
  end

  // Output monitor: records every retired word and every clear pulse.
  initial begin : mon
    forever begin
      @(negedge clk); #2;
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1)
        obs_q.push_back({bus.m_last, bus.m_data});
      if (bus.enc_clr === 1'b1)
        clr_cnt++;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offers samples until n are accepted; called and returns at a negedge.
  task automatic send(input int n, input bit rnd);
    int          rem = n;
    int          guard = 0;
    logic [15:0] smp;
    while (rem > 0 && guard < 400) begin
      smp = 16'($urandom);
      bus.s_sample = smp;
      bus.s_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd) bus.m_ready = 1'($urandom_range(0, 1));
      #1;
      if (bus.enc_en === 1'b1) begin
        rem--;
        chk("enc_sample", bus.enc_sample, smp);
      end
      guard++;
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    chk("send_done", rem, 0);
  endtask

  task automatic wait_last(input bit rnd);
    bit seen = 1'b0;
    int g = 0;
    while (!seen && g < 200) begin
      @(negedge clk);
      if (rnd) bus.m_ready = 1'($urandom_range(0, 1));
      #3;
      if (obs_q.size() > 0) seen = obs_q[obs_q.size()-1][16];
      g++;
    end
    chk("last_seen", seen, 1);
  endtask

  task automatic wait_mvalid();
    int g = 0;
    while (bus.m_valid !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("mvalid_seen", bus.m_valid, 1);
  endtask

  // Reference: codes in acceptance order, four per word, nibble i%4 at
  // bits 4*(i%4); a trailing partial word is zero-padded; a flush landing on
  // a word boundary with nothing held closes with an all-zero word; only the
  // final word of the block carries m_last.
  task automatic cmp_block(input string tag, input bit zero_tail);
    logic [16:0] exp_q[$];
    logic [15:0] w = '0;
    int          n = iss_q.size();
    for (int i = 0; i < n; i++) begin
      w = w | (16'(iss_q[i]) << (4 * (i % 4)));
      if (i % 4 == 3) begin
        exp_q.push_back({1'b0, w});
        w = '0;
      end
    end
    if ((n % 4) != 0 || zero_tail) exp_q.push_back({1'b0, w});
    if (exp_q.size() > 0) exp_q[exp_q.size()-1][16] = 1'b1;
    chk({tag, "_len"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk({tag, "_word"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    iss_q.delete();
  endtask

  initial begin : main
    int c0;
    int n;
    bus.s_valid  = 1'b0;
    bus.s_sample = '0;
    bus.m_ready  = 1'b0;
    bus.flush    = 1'b0;
    reset_n      = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_enc_en",  bus.enc_en,  0);
    chk("rst_enc_clr", bus.enc_clr, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_last",  bus.m_last,  0);
    chk("rst_m_data",  bus.m_data,  16'h0000);

    // Release: one IDLE cycle, one clear cycle, then ready.
    reset_n = 1'b1;
    chk("idle_clr", bus.enc_clr, 0);
    @(negedge clk);
    chk("clr_pulse",  bus.enc_clr, 1);
    chk("clr_sready", bus.s_ready, 0);
    @(negedge clk);
    chk("run_clr",    bus.enc_clr, 0);
    chk("run_sready", bus.s_ready, 1);
    chk("run_mvalid", bus.m_valid, 0);

    // Four back-to-back samples, codes 1..4.
    c0 = clr_cnt;
    bus.m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) scr_q.push_back(4'(i));
    for (int i = 0; i < 4; i++) begin
      bus.s_valid = 1'b1;
      #1;
      chk("b2b_en", bus.enc_en, 1);
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    chk("w1_not_yet", bus.m_valid, 0);
    @(negedge clk);
    chk("w1_valid",  bus.m_valid, 1);
    chk("w1_data",   bus.m_data,  16'h4321);
    chk("w1_last",   bus.m_last,  0);
    chk("w1_bubble", bus.s_ready, 0);

    // Rest of the 8-sample block, codes 5..8.
    send(4, 1'b0);
    wait_last(1'b0);
    @(negedge clk);
    chk("blk_clr",    bus.enc_clr, 1);
    @(negedge clk);
    chk("blk_clr_end", bus.enc_clr, 0);
    chk("blk_sready",  bus.s_ready, 1);
    if (obs_q.size() > 1) chk("w2_last_word", obs_q[1], {1'b1, 16'h8765});
    cmp_block("blk_full", 1'b0);
    chk("blk_clr_cnt", clr_cnt - c0, 1);

    // Output back-pressure: word held for five cycles.
    c0 = clr_cnt;
    bus.m_ready = 1'b0;
    scr_q.push_back(4'h9); scr_q.push_back(4'ha);
    scr_q.push_back(4'hb); scr_q.push_back(4'hc);
    send(4, 1'b0);
    wait_mvalid();
    for (int i = 0; i < 5; i++) begin
      chk("hold_sready", bus.s_ready, 0);
      chk("hold_valid",  bus.m_valid, 1);
      chk("hold_data",   bus.m_data,  16'hcba9);
      @(negedge clk);
    end
    bus.m_ready = 1'b1;
    @(negedge clk);
    chk("hold_retired", bus.m_valid, 0);
    chk("hold_sready1", bus.s_ready, 1);
    send(4, 1'b1);
    wait_last(1'b1);
    bus.m_ready = 1'b1;
    repeat (3) @(negedge clk);
    cmp_block("blk_hold", 1'b0);
    chk("hold_clr_cnt", clr_cnt - c0, 1);

    // Six samples then flush: 4321, then partial 0065 as last.
    c0 = clr_cnt;
    for (int i = 1; i <= 6; i++) scr_q.push_back(4'(i));
    send(6, 1'b0);
    bus.flush = 1'b1;
    wait_last(1'b0);
    bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    if (obs_q.size() > 1) chk("flush_partial", obs_q[1], {1'b1, 16'h0065});
    cmp_block("blk_flush6", 1'b0);
    chk("flush_clr_cnt", clr_cnt - c0, 1);

    // Flush with nothing accepted yet is ignored.
    c0 = clr_cnt;
    bus.flush = 1'b1;
    repeat (10) @(negedge clk);
    chk("flush0_words",  obs_q.size(), 0);
    chk("flush0_clr",    clr_cnt - c0, 0);
    chk("flush0_sready", bus.s_ready, 0);
    bus.flush = 1'b0;
    #1;
    chk("flush0_resume", bus.s_ready, 1);
    @(negedge clk);

    // Flush on a word boundary with the word already gone: empty last word.
    c0 = clr_cnt;
    send(4, 1'b0);
    repeat (4) @(negedge clk);
    bus.flush = 1'b1;
    wait_last(1'b0);
    bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    cmp_block("blk_flush_empty", 1'b1);
    chk("fe_clr_cnt", clr_cnt - c0, 1);

    // Flush on a word boundary with the word still held: it becomes last.
    c0 = clr_cnt;
    bus.m_ready = 1'b0;
    send(4, 1'b0);
    wait_mvalid();
    bus.flush = 1'b1;
    repeat (3) @(negedge clk);
    chk("held_last",  bus.m_last,  1);
    chk("held_valid", bus.m_valid, 1);
    bus.m_ready = 1'b1;
    wait_last(1'b0);
    bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    cmp_block("blk_flush_held", 1'b0);
    chk("fh_clr_cnt", clr_cnt - c0, 1);

    // Randomized blocks: random lengths, valid gaps and back-pressure.
    for (int b = 0; b < 10; b++) begin
      c0 = clr_cnt;
      n = $urandom_range(1, BL);
      if ((n % 4) == 0 && n != BL) n = n - 1;
      send(n, 1'b1);
      if (n != BL) bus.flush = 1'b1;
      wait_last(1'b1);
      bus.flush = 1'b0;
      bus.m_ready = 1'b1;
      repeat (3) @(negedge clk);
      cmp_block("blk_rand", 1'b0);
      chk("rand_clr_cnt", clr_cnt - c0, 1);
    end

    // Reset with a held word and a partly filled pack.
    bus.m_ready = 1'b0;
    send(5, 1'b0);
    @(negedge clk);
    chk("pre_rst_held", bus.m_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("mrst_s_ready", bus.s_ready, 0);
    chk("mrst_enc_en",  bus.enc_en,  0);
    chk("mrst_enc_clr", bus.enc_clr, 0);
    chk("mrst_m_valid", bus.m_valid, 0);
    chk("mrst_m_last",  bus.m_last,  0);
    chk("mrst_m_data",  bus.m_data,  16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    obs_q.delete();
    iss_q.delete();
    bus.m_ready = 1'b1;
    repeat (2) @(negedge clk);
    scr_q.push_back(4'hd); scr_q.push_back(4'he);
    scr_q.push_back(4'hf); scr_q.push_back(4'h1);
    send(4, 1'b0);
    repeat (4) @(negedge clk);
    chk("post_rst_words", obs_q.size(), 1);
    if (obs_q.size() > 0) chk("post_rst_word", obs_q[0], {1'b0, 16'h1fed});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
